// File: rtl/dataflow_input_sync_ctrl.sv
// Start/ready synchroniser for the input processes of a dataflow top.
// Fans ap_start out to PROC_NUM processes, remembers which ones have taken
// the current iteration, and returns ap_ready only once all of them have.
// A watchdog flags processes that sit in a partial sync for too long.
module dataflow_input_sync_ctrl #(
  parameter int          PROC_NUM  = 2,
  parameter int          TIMEOUT   = 1024,
  parameter int          TO_W      = 16,
  // Reset value of the iteration counter; lets the counter be preloaded
  // close to its wrap point.
  parameter logic [31:0] ITER_INIT = 32'd0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ap_start,
  output logic                ap_ready,
  output logic [PROC_NUM-1:0] proc_ap_start,
  input  logic [PROC_NUM-1:0] proc_ap_ready,
  input  logic [PROC_NUM-1:0] proc_ap_idle,
  output logic [PROC_NUM-1:0] ready_flag,
  output logic [PROC_NUM-1:0] dl_vec,
  input  logic                dl_clear,
  output logic [31:0]         iter_cnt,
  output logic [1:0]          sync_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PARTIAL = 2'd2,
    ST_STALL   = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [PROC_NUM-1:0] r_flag;
  logic [PROC_NUM-1:0] r_dl;
  logic [31:0]         r_iter;
  logic [TO_W-1:0]     r_timer;
  logic [TO_W-1:0]     w_timerNext;
  logic [PROC_NUM-1:0] w_dlNext;
  logic                w_startOk;
  logic [PROC_NUM-1:0] w_start;
  logic [PROC_NUM-1:0] w_acc;
  logic [PROC_NUM-1:0] w_eff;
  logic                w_allRdy;

  // Handshake decode: start is suppressed while reset is held so every output is quiet.
  always_comb begin
    w_startOk = ap_start & reset;
    w_start   = w_startOk ? ~r_flag : '0;
    w_acc     = proc_ap_ready & w_start;
    w_eff     = r_flag | w_acc;
    w_allRdy  = w_startOk & (&w_eff);
  end

  assign ap_ready      = w_allRdy;
  assign proc_ap_start = w_start;
  assign ready_flag    = r_flag;
  assign dl_vec        = r_dl;
  assign iter_cnt      = r_iter;
  assign sync_state    = r_state;

  // Next-state, watchdog timer and deadlock-suspect decode.
  always_comb begin
    w_next      = r_state;
    w_timerNext = '0;
    w_dlNext    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_startOk && !w_allRdy)
          w_next = (|w_eff) ? ST_PARTIAL : ST_RUN;
      end
      ST_RUN: begin
        if (w_allRdy)          w_next = ST_IDLE;
        else if (|w_eff)       w_next = ST_PARTIAL;
        else if (!ap_start)    w_next = ST_IDLE;
      end
      ST_PARTIAL: begin
        if (w_allRdy)
          w_next = ST_IDLE;
        else if (ap_start && (r_timer == TO_LAST) && !(|w_acc))
          w_next = ST_STALL;
      end
      ST_STALL: begin
        if (w_allRdy)          w_next = ST_IDLE;
        else if (dl_clear)     w_next = ST_PARTIAL;
      end
      default: w_next = ST_IDLE;
    endcase

    if ((r_state == ST_PARTIAL) && (w_next == ST_PARTIAL) && !(|w_acc)) begin
      if (!ap_start)            w_timerNext = r_timer;
      else if (r_timer != '1)   w_timerNext = r_timer + 1'b1;
      else                      w_timerNext = r_timer;
    end

    if ((r_state == ST_STALL) && (w_next == ST_STALL))
      w_dlNext = r_flag & proc_ap_idle;
  end

  // State, flags, watchdog and iteration counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_flag  <= '0;
      r_dl    <= '0;
      r_timer <= '0;
      r_iter  <= ITER_INIT;
    end else begin
      r_state <= w_next;
      r_dl    <= w_dlNext;
      r_timer <= w_timerNext;
      if (w_allRdy) begin
        r_flag <= '0;
        r_iter <= r_iter + 32'd1;
      end else begin
        r_flag <= r_flag | w_acc;
      end
    end
  end

endmodule

// File: tb/tb_dataflow_input_sync_ctrl.sv
// Directed bench for dataflow_input_sync_ctrl with a queue-based scoreboard.
module tb_dataflow_input_sync_ctrl;

  localparam int          PN   = 2;
  localparam logic [31:0] INIT = 32'hFFFF_FFFC;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ap_start = 1'b0;
  logic [PN-1:0] proc_ap_ready = '0;
  logic [PN-1:0] proc_ap_idle = '0;
  logic          dl_clear = 1'b0;

  logic          ap_ready, ap_ready2;
  logic [PN-1:0] proc_ap_start, proc_ap_start2;
  logic [PN-1:0] ready_flag, ready_flag2;
  logic [PN-1:0] dl_vec, dl_vec2;
  logic [31:0]   iter_cnt, iter_cnt2;
  logic [1:0]    sync_state, sync_state2;

  int errors = 0;
  int checks = 0;
  logic [31:0] expCnt = 32'd0;

  typedef struct packed {
    logic        ar;
    logic [1:0]  ps;
    logic [1:0]  rf;
    logic [1:0]  dl;
    logic [1:0]  st;
    logic [31:0] ic;
  } exp_t;

  exp_t  expQ[$];
  string tagQ[$];

  dataflow_input_sync_ctrl #(.PROC_NUM(PN), .TIMEOUT(8), .TO_W(4)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .proc_ap_start(proc_ap_start), .proc_ap_ready(proc_ap_ready),
    .proc_ap_idle(proc_ap_idle), .ready_flag(ready_flag), .dl_vec(dl_vec),
    .dl_clear(dl_clear), .iter_cnt(iter_cnt), .sync_state(sync_state)
  );

  // Second instance shares all inputs but starts its counter near the wrap point.
  dataflow_input_sync_ctrl #(.PROC_NUM(PN), .TIMEOUT(8), .TO_W(4), .ITER_INIT(INIT)) dutWrap (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready2),
    .proc_ap_start(proc_ap_start2), .proc_ap_ready(proc_ap_ready),
    .proc_ap_idle(proc_ap_idle), .ready_flag(ready_flag2), .dl_vec(dl_vec2),
    .dl_clear(dl_clear), .iter_cnt(iter_cnt2), .sync_state(sync_state2)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] r, input logic [1:0] idle,
                               input logic clr);
    @(negedge clock);
    ap_start      = s;
    proc_ap_ready = r;
    proc_ap_idle  = idle;
    dl_clear      = clr;
  endtask

  task automatic pushExp(input string tag, input logic ar, input logic [1:0] ps,
                         input logic [1:0] rf, input logic [1:0] dl, input logic [1:0] st);
    exp_t e;
    e.ar = ar; e.ps = ps; e.rf = rf; e.dl = dl; e.st = st; e.ic = expCnt;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic checkOutput();
    exp_t  e;
    string t;
    #1;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      cmp({t, ".ap_ready"},      {31'd0, ap_ready},      {31'd0, e.ar});
      cmp({t, ".proc_ap_start"}, {30'd0, proc_ap_start}, {30'd0, e.ps});
      cmp({t, ".ready_flag"},    {30'd0, ready_flag},    {30'd0, e.rf});
      cmp({t, ".dl_vec"},        {30'd0, dl_vec},        {30'd0, e.dl});
      cmp({t, ".sync_state"},    {30'd0, sync_state},    {30'd0, e.st});
      cmp({t, ".iter_cnt"},      iter_cnt,               e.ic);
    end
  endtask

  task automatic step(input string tag, input logic s, input logic [1:0] r,
                      input logic [1:0] idle, input logic clr, input logic ar,
                      input logic [1:0] ps, input logic [1:0] rf, input logic [1:0] dl,
                      input logic [1:0] st);
    applyStimulus(s, r, idle, clr);
    pushExp(tag, ar, ps, rf, dl, st);
    checkOutput();
    if (ar) expCnt = expCnt + 32'd1;
  endtask

  // Directed sequence.
  initial begin
    logic [31:0] e2;
    ap_start = 1'b1;
    proc_ap_ready = 2'b11;

    // Held in reset: every output quiet even with start and readies high.
    step("rst_hold", 1, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    ap_start = 1'b0;
    proc_ap_ready = 2'b00;

    // Both processes accept in the start cycle.
    step("t1_same",  1, 2'b11, 2'b00, 0, 1, 2'b11, 2'b00, 2'b00, 2'd0);
    step("t1_after", 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'd0);

    // Staggered acceptance, with a stray ready from an already-accepted process.
    step("t2_start", 1, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 2'd0);
    step("t2_run",   1, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 2'd1);
    step("t2_p0rdy", 1, 2'b01, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 2'd1);
    step("t2_part",  1, 2'b00, 2'b00, 0, 0, 2'b10, 2'b01, 2'b00, 2'd2);
    step("t2_spur",  1, 2'b01, 2'b00, 0, 0, 2'b10, 2'b01, 2'b00, 2'd2);
    step("t2_p1rdy", 1, 2'b10, 2'b00, 0, 1, 2'b10, 2'b01, 2'b00, 2'd2);
    step("t2_done",  0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'd0);

    // Watchdog: proc 1 never readies, stall after exactly 8 partial cycles.
    step("t3_p0rdy", 1, 2'b01, 2'b01, 0, 0, 2'b11, 2'b00, 2'b00, 2'd0);
    for (int k = 0; k < 8; k++)
      step($sformatf("t3_wait%0d", k), 1, 2'b00, 2'b01, 0, 0, 2'b10, 2'b01, 2'b00, 2'd2);
    step("t3_stall", 1, 2'b00, 2'b01, 0, 0, 2'b10, 2'b01, 2'b00, 2'd3);
    step("t3_dl",    1, 2'b00, 2'b01, 0, 0, 2'b10, 2'b01, 2'b01, 2'd3);

    // dl_clear returns to partial with a fresh timer; stall re-declared.
    step("t4_clr",   1, 2'b00, 2'b01, 1, 0, 2'b10, 2'b01, 2'b01, 2'd3);
    for (int k = 0; k < 8; k++)
      step($sformatf("t4_wait%0d", k), 1, 2'b00, 2'b01, 0, 0, 2'b10, 2'b01, 2'b00, 2'd2);
    step("t4_stall", 1, 2'b00, 2'b01, 0, 0, 2'b10, 2'b01, 2'b00, 2'd3);
    step("t4_dl",    1, 2'b00, 2'b01, 0, 0, 2'b10, 2'b01, 2'b01, 2'd3);
    // Completion wins over a simultaneous clear.
    step("t4_prio",  1, 2'b10, 2'b01, 1, 1, 2'b10, 2'b01, 2'b01, 2'd3);
    step("t4_done",  0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'd0);

    // Asynchronous reset in the middle of a partial sync.
    step("t5_p0rdy", 1, 2'b01, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 2'd0);
    step("t5_part",  1, 2'b00, 2'b00, 0, 0, 2'b10, 2'b01, 2'b00, 2'd2);
    #2;
    reset = 1'b0;
    expCnt = 32'd0;
    pushExp("t5_rst", 0, 2'b00, 2'b00, 2'b00, 2'd0);
    checkOutput();
    @(negedge clock);
    reset = 1'b1;
    step("t5_rel",   1, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 2'd1);
    step("t5_drop",  0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'd1);

    // ap_start dropping mid-iteration holds flags and state.
    step("t6_p0rdy", 1, 2'b01, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 2'd0);
    step("t6_drop",  0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00, 2'd2);
    step("t6_hold",  0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00, 2'd2);
    step("t6_p1rdy", 1, 2'b10, 2'b00, 0, 1, 2'b10, 2'b01, 2'b00, 2'd2);
    step("t6_done",  0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'd0);

    // Back-to-back iterations; the preloaded instance wraps through zero.
    for (int k = 0; k < 6; k++) begin
      e2 = expCnt + INIT;
      step($sformatf("t7_b2b%0d", k), 1, 2'b11, 2'b00, 0, 1, 2'b11, 2'b00, 2'b00, 2'd0);
      cmp($sformatf("t7_wrap%0d.iter_cnt", k), iter_cnt2, e2);
    end
    e2 = expCnt + INIT;
    step("t7_end",   0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'd0);
    cmp("t7_wrapEnd.iter_cnt", iter_cnt2, e2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
